// File: rtl/imul_rr_arbiter.sv
// Round-robin arbiter sharing one val/rdy multiplier between p_nreqs requesters.
// One transaction in flight; the buffered product is returned only to its owner.
module imul_rr_arbiter #(
  parameter int unsigned p_nreqs    = 2,
  parameter int unsigned p_id_nbits = (p_nreqs > 1) ? $clog2(p_nreqs) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_nreqs-1:0]     istream_val,
  output logic [p_nreqs-1:0]     istream_rdy,
  input  logic [64*p_nreqs-1:0]  istream_msg,
  output logic [p_nreqs-1:0]     ostream_val,
  input  logic [p_nreqs-1:0]     ostream_rdy,
  output logic [31:0]            ostream_msg,
  output logic                   mul_req_val,
  input  logic                   mul_req_rdy,
  output logic [63:0]            mul_req_msg,
  input  logic                   mul_resp_val,
  output logic                   mul_resp_rdy,
  input  logic [31:0]            mul_resp_msg
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e                r_state;
  logic [p_id_nbits-1:0] r_ptr;
  logic [p_id_nbits-1:0] r_owner;
  logic [31:0]           r_resp_buf;

  logic [p_id_nbits-1:0] w_grant;
  logic [p_id_nbits-1:0] w_ptr_nxt;
  logic                  w_any;
  logic                  w_found;
  logic                  w_req_fire;
  logic                  w_owner_rdy;
  logic [63:0]           w_msg;

  // Search starts at r_ptr and wraps, so the last winner has lowest priority.
  always_comb begin
    int unsigned idx;
    w_grant = '0;
    w_found = 1'b0;
    idx     = 0;
    for (int unsigned j = 0; j < p_nreqs; j++) begin
      idx = (32'(r_ptr) + j) % p_nreqs;
      if (!w_found && istream_val[p_id_nbits'(idx)]) begin
        w_found = 1'b1;
        w_grant = p_id_nbits'(idx);
      end
    end
  end

  always_comb begin
    w_msg       = '0;
    w_owner_rdy = 1'b0;
    for (int unsigned i = 0; i < p_nreqs; i++) begin
      if (w_grant == p_id_nbits'(i)) w_msg = istream_msg[64*i +: 64];
      if (r_owner == p_id_nbits'(i)) w_owner_rdy = ostream_rdy[i];
    end
  end

  assign w_any     = |istream_val;
  assign w_ptr_nxt = (w_grant == p_id_nbits'(p_nreqs - 1)) ? '0 : w_grant + 1'b1;

  // Every handshake output is gated by reset so nothing leaks while it is held.
  assign mul_req_val  = reset && (r_state == StIdle) && w_any;
  assign mul_req_msg  = w_msg;
  assign w_req_fire   = mul_req_val && mul_req_rdy;
  assign mul_resp_rdy = reset && (r_state == StWait);
  assign ostream_msg  = r_resp_buf;

  always_comb begin
    istream_rdy = '0;
    ostream_val = '0;
    for (int unsigned i = 0; i < p_nreqs; i++) begin
      istream_rdy[i] = mul_req_val && mul_req_rdy && (w_grant == p_id_nbits'(i));
      ostream_val[i] = reset && (r_state == StResp) && (r_owner == p_id_nbits'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_resp_buf <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_req_fire) begin
            r_owner <= w_grant;
            r_ptr   <= w_ptr_nxt;
            r_state <= StWait;
          end
        end
        StWait: begin
          if (mul_resp_val) begin
            r_resp_buf <= mul_resp_msg;
            r_state    <= StResp;
          end
        end
        StResp: begin
          if (w_owner_rdy) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imul_rr_arbiter.sv
// Directed bench for imul_rr_arbiter: 2-requester and 4-requester instances,
// multiplier side driven by hand from the bench.
module tb_imul_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_total = 0;
  int n_bad   = 0;

  logic [1:0]   v2, r2, ov2, or2;
  logic [127:0] m2;
  logic [31:0]  om2, pm2;
  logic         qv2, qr2, pv2, pr2;
  logic [63:0]  qm2;

  logic [3:0]   v4, r4, ov4, or4;
  logic [255:0] m4;
  logic [31:0]  om4, pm4;
  logic         qv4, qr4, pv4, pr4;
  logic [63:0]  qm4;

  imul_rr_arbiter #(.p_nreqs(2)) dut2 (
    .clk(clk), .reset(rst_n),
    .istream_val(v2), .istream_rdy(r2), .istream_msg(m2),
    .ostream_val(ov2), .ostream_rdy(or2), .ostream_msg(om2),
    .mul_req_val(qv2), .mul_req_rdy(qr2), .mul_req_msg(qm2),
    .mul_resp_val(pv2), .mul_resp_rdy(pr2), .mul_resp_msg(pm2)
  );

  imul_rr_arbiter #(.p_nreqs(4)) dut4 (
    .clk(clk), .reset(rst_n),
    .istream_val(v4), .istream_rdy(r4), .istream_msg(m4),
    .ostream_val(ov4), .ostream_rdy(or4), .ostream_msg(om4),
    .mul_req_val(qv4), .mul_req_rdy(qr4), .mul_req_msg(qm4),
    .mul_resp_val(pv4), .mul_resp_rdy(pr4), .mul_resp_msg(pm4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v2 = '0; or2 = '0; pv2 = 1'b0; pm2 = '0; qr2 = 1'b1;
    v4 = '0; or4 = '0; pv4 = 1'b0; pm4 = '0; qr4 = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One full transaction on dut2 from IDLE; stub product is a*b of the issued request.
  task automatic serve2(input int g, input logic [31:0] exp_prod, input string tag);
    logic [31:0] a, b;
    #1;
    check_eq({tag, "_grant"}, 64'(r2), 64'(1 << g));
    check_eq({tag, "_reqval"}, 64'(qv2), 64'd1);
    a = qm2[63:32];
    b = qm2[31:0];
    tick();
    pv2 = 1'b1;
    pm2 = a * b;
    #1;
    check_eq({tag, "_nocomb"}, 64'(ov2), 64'd0);
    tick();
    pv2 = 1'b0;
    #1;
    check_eq({tag, "_oval"}, 64'(ov2), 64'(1 << g));
    check_eq({tag, "_omsg"}, 64'(om2), 64'(exp_prod));
    or2 = 2'b11;
    tick();
    or2 = 2'b00;
  endtask

  task automatic serve4(input int g, input logic [31:0] exp_prod, input string tag);
    logic [31:0] a, b;
    #1;
    check_eq({tag, "_grant"}, 64'(r4), 64'(1 << g));
    a = qm4[63:32];
    b = qm4[31:0];
    tick();
    pv4 = 1'b1;
    pm4 = a * b;
    tick();
    pv4 = 1'b0;
    #1;
    check_eq({tag, "_oval"}, 64'(ov4), 64'(1 << g));
    check_eq({tag, "_omsg"}, 64'(om4), 64'(exp_prod));
    or4 = 4'hF;
    tick();
    or4 = 4'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    v2 = 2'b11; m2 = '0; or2 = '0; qr2 = 1'b1; pv2 = 1'b1; pm2 = 32'h1234;
    v4 = 4'hF;  m4 = '0; or4 = '0; qr4 = 1'b1; pv4 = 1'b0; pm4 = '0;
    #2;
    check_eq("rst_irdy", 64'(r2), 64'd0);
    check_eq("rst_reqval", 64'(qv2), 64'd0);
    check_eq("rst_resprdy", 64'(pr2), 64'd0);
    check_eq("rst_oval", 64'(ov2), 64'd0);
    check_eq("rst_omsg", 64'(om2), 64'd0);
    check_eq("rst_reqval4", 64'(qv4), 64'd0);
    tick();
    v2 = '0; v4 = '0; pv2 = 1'b0; pm2 = '0;
    rst_n = 1'b1;

    // 1: single request {3,7}, response after 4 cycles
    m2 = {32'd9, 32'd9, 32'd3, 32'd7};
    v2 = 2'b01;
    #1;
    check_eq("t1_reqval", 64'(qv2), 64'd1);
    check_eq("t1_reqmsg", qm2, {32'd3, 32'd7});
    check_eq("t1_irdy", 64'(r2), 64'd1);
    tick();
    v2 = 2'b00;
    #1;
    check_eq("t1_wait_irdy", 64'(r2), 64'd0);
    check_eq("t1_wait_reqval", 64'(qv2), 64'd0);
    check_eq("t1_wait_resprdy", 64'(pr2), 64'd1);
    tick(); tick(); tick();
    pv2 = 1'b1;
    pm2 = 32'd21;
    #1;
    check_eq("t1_nocomb", 64'(ov2), 64'd0);
    tick();
    pv2 = 1'b0;
    #1;
    check_eq("t1_oval", 64'(ov2), 64'd1);
    check_eq("t1_omsg", 64'(om2), 64'h15);
    check_eq("t1_resp_resprdy", 64'(pr2), 64'd0);
    or2 = 2'b01;
    tick();
    or2 = 2'b00;
    v2 = 2'b11;
    #1;
    check_eq("t1_ptr_grant", 64'(r2), 64'd2);
    check_eq("t1_ptr_msg", qm2, {32'd9, 32'd9});
    v2 = 2'b00;

    // 2: both requesters valid, grants alternate
    do_reset();
    m2 = {32'd6, 32'd6, 32'd2, 32'd5};
    v2 = 2'b11;
    serve2(0, 32'd10, "t2a");
    serve2(1, 32'd36, "t2b");
    serve2(0, 32'd10, "t2c");
    serve2(1, 32'd36, "t2d");

    // 3: owner stalls ostream_rdy for 5 cycles; non-owner rdy is ignored
    #1;
    check_eq("t3_grant", 64'(r2), 64'd1);
    tick();
    pv2 = 1'b1;
    pm2 = 32'd10;
    tick();
    pv2 = 1'b0;
    or2 = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("t3_hold_oval", 64'(ov2), 64'd1);
      check_eq("t3_hold_omsg", 64'(om2), 64'd10);
      check_eq("t3_hold_reqval", 64'(qv2), 64'd0);
      check_eq("t3_hold_irdy", 64'(r2), 64'd0);
      tick();
    end
    or2 = 2'b01;
    tick();
    or2 = 2'b00;
    #1;
    check_eq("t3_next_grant", 64'(r2), 64'd2);
    check_eq("t3_next_msg", qm2, {32'd6, 32'd6});
    serve2(1, 32'd36, "t3n");
    v2 = 2'b00;

    // 4: multiplier not ready for 3 cycles, only requester 1 valid
    do_reset();
    v2 = 2'b10;
    qr2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_stall_msg", qm2, {32'd6, 32'd6});
      check_eq("t4_stall_irdy", 64'(r2), 64'd0);
      check_eq("t4_stall_reqval", 64'(qv2), 64'd1);
      tick();
    end
    qr2 = 1'b1;
    serve2(1, 32'd36, "t4");
    v2 = 2'b11;
    #1;
    check_eq("t4_wrap_grant", 64'(r2), 64'd1);
    v2 = 2'b00;

    // 5: async reset while waiting on the multiplier
    do_reset();
    m2 = {32'd6, 32'd6, 32'hFFFF_FFFF, 32'd2};
    v2 = 2'b01;
    tick();
    v2 = 2'b11;
    #1;
    check_eq("t5_wait", 64'(pr2), 64'd1);
    #2;
    rst_n = 1'b0;
    pv2 = 1'b1;
    pm2 = 32'hDEAD;
    #1;
    check_eq("t5_rst_irdy", 64'(r2), 64'd0);
    check_eq("t5_rst_oval", 64'(ov2), 64'd0);
    check_eq("t5_rst_reqval", 64'(qv2), 64'd0);
    check_eq("t5_rst_resprdy", 64'(pr2), 64'd0);
    tick();
    tick();
    pv2 = 1'b0;
    v2 = 2'b00;
    rst_n = 1'b1;
    tick();
    #1;
    check_eq("t5_no_stale", 64'(ov2), 64'd0);
    check_eq("t5_idle_resprdy", 64'(pr2), 64'd0);
    v2 = 2'b11;
    serve2(0, 32'hFFFF_FFFE, "t5");
    v2 = 2'b00;

    // 6: four requesters, 1 and 3 valid, ptr brought to 2 first
    do_reset();
    for (int i = 0; i < 4; i++) m4[64*i +: 64] = {32'(i + 2), 32'd3};
    v4 = 4'b0010;
    serve4(1, 32'd9, "t6pre");
    v4 = 4'b1010;
    serve4(3, 32'd15, "t6a");
    serve4(1, 32'd9, "t6b");
    serve4(3, 32'd15, "t6c");
    serve4(1, 32'd9, "t6d");
    v4 = 4'b0000;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
